// File: rtl/image_frame_tx.sv
`timescale 1ns/1ps
// image_frame_tx: streams a stored W x W frame from synchronous memory in raster order
// as a valid/ready pixel stream with line/frame markers and a 2-entry output buffer.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for i_start, address counters held at zero
//   S_STREAM | issuing memory reads whenever the buffer has room
//   S_GAP    | idle cycles between lines, no reads
//   S_DRAIN  | all reads issued; wait for buffer empty, then pulse o_done
module image_frame_tx #(
    parameter int W        = 64,
    parameter int DATA_W   = 24,
    parameter int LINE_GAP = 0
) (
    input  logic                   axi_clk,
    input  logic                   reset_n,
    input  logic                   i_start,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_mem_rd_en,
    output logic [2*$clog2(W)-1:0] o_mem_addr,
    input  logic [DATA_W-1:0]      i_mem_rd_data,
    output logic [DATA_W-1:0]      o_rgb_data,
    output logic                   o_rgb_data_valid,
    input  logic                   i_ready,
    output logic                   o_line_end,
    output logic                   o_frame_end
);
    localparam int LW = $clog2(W);
    localparam logic [LW-1:0] LAST = LW'(W - 1);
    localparam logic [7:0] GAP_LOAD = (LINE_GAP > 0) ? 8'(LINE_GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_GAP    = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [LW-1:0]     col_q, col_d, line_q, line_d;
    logic [7:0]        gap_q, gap_d;
    logic              inf_q, inf_le_q, inf_fe_q;
    logic [DATA_W-1:0] fifo_data_q [2];
    logic [1:0]        fifo_le_q, fifo_fe_q;
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;
    logic [2:0]        level;
    logic              fifo_valid, pop, rd_en, last_col, last_line, can_issue;

    assign fifo_valid = (count_q != 2'd0);
    assign pop        = fifo_valid && i_ready;
    assign last_col   = (col_q == LAST);
    assign last_line  = (line_q == LAST);

    // Buffered + in-flight entries after this cycle's pop; a new read must still fit.
    assign level     = {1'b0, count_q} + {2'b00, inf_q} - {2'b00, pop};
    assign can_issue = (level < 3'd2);

    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (rd_en && last_col) begin
                    if (last_line) begin
                        state_d = S_DRAIN;
                    end else if (LINE_GAP > 0) begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = S_STREAM;
                end
            end
            S_DRAIN: begin
                if (!fifo_valid && !inf_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state_q != S_IDLE);
        o_done = (state_q == S_DRAIN) && !fifo_valid && !inf_q;
        rd_en  = (state_q == S_STREAM) && can_issue;
    end

    always_comb begin
        col_d  = col_q;
        line_d = line_q;
        gap_d  = gap_q;
        if (state_q == S_IDLE) begin
            col_d  = '0;
            line_d = '0;
        end else if (rd_en && !(last_col && last_line)) begin
            if (last_col) begin
                col_d  = '0;
                line_d = line_q + LW'(1);
            end else begin
                col_d = col_q + LW'(1);
            end
        end
        if (state_q == S_STREAM) begin
            gap_d = GAP_LOAD;
        end else if (state_q == S_GAP && gap_q != 8'd0) begin
            gap_d = gap_q - 8'd1;
        end
    end

    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n) begin
            col_q    <= '0;
            line_q   <= '0;
            gap_q    <= '0;
            inf_q    <= 1'b0;
            inf_le_q <= 1'b0;
            inf_fe_q <= 1'b0;
        end else begin
            col_q    <= col_d;
            line_q   <= line_d;
            gap_q    <= gap_d;
            inf_q    <= rd_en;
            inf_le_q <= rd_en && last_col;
            inf_fe_q <= rd_en && last_col && last_line;
        end
    end

    always_comb begin
        count_d = count_q;
        if (inf_q && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!inf_q && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    // Sideband flags travel with the data so the head entry alone drives all outputs.
    always_ff @(posedge axi_clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_le_q      <= '0;
            fifo_fe_q      <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            count_q        <= '0;
        end else begin
            if (inf_q) begin
                fifo_data_q[wr_ptr_q] <= i_mem_rd_data;
                fifo_le_q[wr_ptr_q]   <= inf_le_q;
                fifo_fe_q[wr_ptr_q]   <= inf_fe_q;
                wr_ptr_q              <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign o_mem_rd_en      = rd_en;
    assign o_mem_addr       = {line_q, col_q};
    assign o_rgb_data_valid = fifo_valid;
    assign o_rgb_data       = fifo_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign o_line_end       = fifo_valid && fifo_le_q[rd_ptr_q];
    assign o_frame_end      = fifo_valid && fifo_fe_q[rd_ptr_q];

endmodule

// File: tb/tb_image_frame_tx.sv
`timescale 1ns/1ps
// Bench for image_frame_tx: instance u0 has no line gap, u1 has LINE_GAP=4.
// Expected beats are queued at start; negedge monitors compare whenever valid is high.
module tb_image_frame_tx;
    localparam int W    = 64;
    localparam int NPIX = W * W;
    localparam int GAP  = 4;

    logic axi_clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 axi_clk = ~axi_clk;

    logic        start0 = 1'b0, ready0 = 1'b1, busy0, done0, rd0, valid0, le0, fe0;
    logic [11:0] addr0;
    logic [23:0] rdata0 = '0, data0;
    logic        start1 = 1'b0, ready1 = 1'b1, busy1, done1, rd1, valid1, le1, fe1;
    logic [11:0] addr1;
    logic [23:0] rdata1 = '0, data1;

    image_frame_tx #(.W(W), .DATA_W(24), .LINE_GAP(0)) u0 (
        .axi_clk(axi_clk), .reset_n(reset_n), .i_start(start0), .o_busy(busy0),
        .o_done(done0), .o_mem_rd_en(rd0), .o_mem_addr(addr0), .i_mem_rd_data(rdata0),
        .o_rgb_data(data0), .o_rgb_data_valid(valid0), .i_ready(ready0),
        .o_line_end(le0), .o_frame_end(fe0));

    image_frame_tx #(.W(W), .DATA_W(24), .LINE_GAP(GAP)) u1 (
        .axi_clk(axi_clk), .reset_n(reset_n), .i_start(start1), .o_busy(busy1),
        .o_done(done1), .o_mem_rd_en(rd1), .o_mem_addr(addr1), .i_mem_rd_data(rdata1),
        .o_rgb_data(data1), .o_rgb_data_valid(valid1), .i_ready(ready1),
        .o_line_end(le1), .o_frame_end(fe1));

    function automatic logic [23:0] pix(input int k);
        return {12'hA5C, k[11:0]};
    endfunction

    function automatic logic [25:0] exp_beat(input int k);
        return {pix(k), ((k % W) == W - 1), (k == NPIX - 1)};
    endfunction

    // Synchronous memory: data one cycle after the strobe, junk otherwise.
    always @(posedge axi_clk) begin
        rdata0 <= rd0 ? pix(int'(addr0)) : 24'hBADBAD;
        rdata1 <= rd1 ? pix(int'(addr1)) : 24'hBADBAD;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    logic [25:0] exp0[$];
    logic [25:0] exp1[$];
    logic [11:0] rd_log0[$];

    int cyc0 = 0, beats0 = 0, iss0 = 0, max_out0 = 0, done_cnt0 = 0, first_cyc0 = 0, fe_cyc0 = 0;
    bit seen_first0 = 1'b0, fe_pend0 = 1'b0;

    always @(negedge axi_clk) begin
        cyc0++;
        if (fe_pend0) begin
            check("u0_done_after_frame_end", {busy0, done0}, 2'b11);
            fe_pend0 = 1'b0;
        end
        if (done0) done_cnt0++;
        if (rd0) begin
            iss0++;
            rd_log0.push_back(addr0);
        end
        if (valid0) begin
            if (!seen_first0) begin
                seen_first0 = 1'b1;
                first_cyc0  = cyc0;
            end
            check("u0_beat_expected", exp0.size() != 0, 1);
            if (exp0.size() != 0) begin
                check("u0_beat", {data0, le0, fe0}, exp0[0]);
                if (ready0) void'(exp0.pop_front());
            end
            if (ready0) begin
                beats0++;
                if (fe0) begin
                    fe_pend0 = 1'b1;
                    fe_cyc0  = cyc0;
                end
            end
        end
        if (iss0 - beats0 > max_out0) max_out0 = iss0 - beats0;
    end

    int cyc1 = 0, beats1 = 0, run1 = 0, gaps1 = 0, first_cyc1 = 0, fe_cyc1 = 0;
    bit in_frame1 = 1'b0, started1 = 1'b0;

    always @(negedge axi_clk) begin
        cyc1++;
        if (in_frame1 && !valid1) run1++;
        if (valid1) begin
            if (!started1) begin
                started1   = 1'b1;
                in_frame1  = 1'b1;
                first_cyc1 = cyc1;
            end
            if (run1 != 0) begin
                check("u1_line_gap_len", run1, GAP);
                gaps1++;
                run1 = 0;
            end
            check("u1_beat_expected", exp1.size() != 0, 1);
            if (exp1.size() != 0) begin
                check("u1_beat", {data1, le1, fe1}, exp1[0]);
                if (ready1) void'(exp1.pop_front());
            end
            if (ready1) begin
                beats1++;
                if (fe1) begin
                    in_frame1 = 1'b0;
                    fe_cyc1   = cyc1;
                end
            end
        end
    end

    bit rand_rdy = 1'b0;
    initial forever begin
        @(posedge axi_clk);
        #1;
        if (rand_rdy) ready0 = ($urandom_range(0, 1) == 1);
    end

    // Queues the expected frame, pulses start and checks the start latency.
    task automatic start_frame0();
        for (int k = 0; k < NPIX; k++) exp0.push_back(exp_beat(k));
        @(posedge axi_clk);
        #1 start0 = 1'b1;
        @(posedge axi_clk);
        #1 start0 = 1'b0;
        @(negedge axi_clk);
        check("u0_first_read", {busy0, rd0, addr0, valid0}, {1'b1, 1'b1, 12'd0, 1'b0});
        @(negedge axi_clk);
        check("u0_valid_low_after_e1", valid0, 0);
        @(negedge axi_clk);
        check("u0_valid_high_after_e2", valid0, 1);
    endtask

    task automatic wait_done(input int which, input int budget);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < budget) begin
            @(negedge axi_clk);
            n++;
            seen = (which == 0) ? done0 : done1;
        end
        check((which == 0) ? "u0_done_within_budget" : "u1_done_within_budget", seen, 1);
    endtask

    task automatic wait_beats0(input int target, input int budget);
        int n = 0;
        while (beats0 < target && n < budget) begin
            @(negedge axi_clk);
            n++;
        end
        check("u0_reach_beat", beats0 >= target, 1);
    endtask

    initial begin
        int b, d, i0;
        repeat (3) @(negedge axi_clk);
        check("u0_reset_outputs", {busy0, done0, rd0, addr0, data0, valid0, le0, fe0}, '0);
        check("u1_reset_outputs", {busy1, done1, rd1, addr1, data1, valid1, le1, fe1}, '0);
        #2 reset_n = 1'b1;

        // Nominal frame, ready always high.
        seen_first0 = 1'b0;
        b = beats0;
        d = done_cnt0;
        start_frame0();
        wait_done(0, NPIX + 100);
        @(negedge axi_clk);
        check("u0_busy_falls_with_done", {busy0, done0}, 2'b00);
        repeat (3) @(negedge axi_clk);
        check("u0_nominal_beats", beats0 - b, NPIX);
        check("u0_nominal_back_to_back", fe_cyc0 - first_cyc0 + 1, NPIX);
        check("u0_done_single_pulse", done_cnt0 - d, 1);
        check("u0_queue_empty_nominal", exp0.size(), 0);

        // Random backpressure.
        max_out0 = 0;
        b = beats0;
        d = done_cnt0;
        rand_rdy = 1'b1;
        start_frame0();
        wait_done(0, 4 * NPIX);
        rand_rdy = 1'b0;
        @(posedge axi_clk);
        #1 ready0 = 1'b1;
        repeat (3) @(negedge axi_clk);
        check("u0_bp_beats", beats0 - b, NPIX);
        check("u0_bp_done_pulses", done_cnt0 - d, 1);
        check("u0_bp_max_outstanding", max_out0, 2);
        check("u0_queue_empty_bp", exp0.size(), 0);

        // Ready held low from start: two reads only, pixel 0 held.
        @(posedge axi_clk);
        #1 ready0 = 1'b0;
        rd_log0.delete();
        i0 = iss0;
        start_frame0();
        repeat (20) @(negedge axi_clk);
        check("u0_stall_read_count", iss0 - i0, 2);
        if (rd_log0.size() >= 2)
            check("u0_stall_read_addrs", {rd_log0[0], rd_log0[1]}, {12'd0, 12'd1});
        check("u0_stall_holds_pixel0", {valid0, data0, rd0}, {1'b1, pix(0), 1'b0});
        @(posedge axi_clk);
        #1 ready0 = 1'b1;
        wait_done(0, NPIX + 100);
        repeat (2) @(negedge axi_clk);
        check("u0_queue_empty_stall", exp0.size(), 0);

        // Start mid-frame ignored; start on the done cycle ignored; start after done runs.
        b = beats0;
        start_frame0();
        wait_beats0(b + 2000, NPIX);
        @(posedge axi_clk);
        #1 start0 = 1'b1;
        @(posedge axi_clk);
        #1 start0 = 1'b0;
        wait_done(0, NPIX + 100);
        #1 start0 = 1'b1;
        @(posedge axi_clk);
        #1 start0 = 1'b0;
        @(negedge axi_clk);
        check("u0_start_on_done_ignored", {busy0, rd0, valid0}, 3'b000);
        check("u0_midframe_start_beats", beats0 - b, NPIX);
        repeat (5) @(negedge axi_clk);
        start_frame0();
        wait_done(0, NPIX + 100);
        repeat (2) @(negedge axi_clk);
        check("u0_queue_empty_restart", exp0.size(), 0);

        // Asynchronous reset mid-frame.
        b = beats0;
        start_frame0();
        wait_beats0(b + 1000, NPIX);
        #2 reset_n = 1'b0;
        #1 check("u0_async_reset_outputs", {busy0, done0, rd0, addr0, data0, valid0, le0, fe0}, '0);
        exp0.delete();
        repeat (2) @(negedge axi_clk);
        #2 reset_n = 1'b1;
        repeat (3) @(negedge axi_clk);
        check("u0_idle_after_reset", {busy0, rd0, valid0, done0}, 4'b0000);
        start_frame0();
        wait_done(0, NPIX + 100);
        repeat (2) @(negedge axi_clk);
        check("u0_queue_empty_after_reset", exp0.size(), 0);

        // Line gap instance.
        for (int k = 0; k < NPIX; k++) exp1.push_back(exp_beat(k));
        @(posedge axi_clk);
        #1 start1 = 1'b1;
        @(posedge axi_clk);
        #1 start1 = 1'b0;
        wait_done(1, NPIX + 64 * GAP + 100);
        repeat (3) @(negedge axi_clk);
        check("u1_gap_count", gaps1, W - 1);
        check("u1_frame_span", fe_cyc1 - first_cyc1 + 1, NPIX + (W - 1) * GAP);
        check("u1_beats", beats1, NPIX);
        check("u1_queue_empty", exp1.size(), 0);
        check("u1_idle_after_done", busy1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
